hamming_encoder: RTL and testbench

Pipelined Hamming encoder: accepts data words over a valid/ready handshake, computes the parity bits, and emits the full Hamming-coded word with parity at power-of-two positions and data at all other positions. It is the write-side counterpart of the existing Hamming splitter/decoder path and feeds the protected flip-flop arrays under SEU test. It also provides an optional single-bit fault-injection hook and a count of words emitted.

---
 rtl/hamming_pkg.sv | 16 +
 rtl/hamming_parity_gen.sv | 33 +++
 rtl/hamming_encoder.sv | 110 +++++++++++
 tb/tb_hamming_encoder.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/hamming_pkg.sv
// Shared helpers for the Hamming encode path: position classification and
// the data-bit index carried by each non-parity position.
package hamming_pkg;

  // inject_pos value that leaves the output word untouched
  localparam int INJ_NONE = 0;

  function automatic bit is_pow2(int i);
    return (i > 0) && ((i & (i - 1)) == 0);
  endfunction

  function automatic int data_index(int pos);
    return pos - $clog2(pos) - 1;
  endfunction

endpackage

// File: rtl/hamming_parity_gen.sv
// Combinational even-parity generator: parity bit k covers every data-bearing
// position whose 1-based index has bit k set.
module hamming_parity_gen
  import hamming_pkg::*;
#(
  parameter int parity_bits = 4,
  parameter int data_width  = (1 << parity_bits) - parity_bits - 1,
  parameter int total_width = (1 << parity_bits) - 1
) (
  input  logic [data_width-1:0]  data,
  output logic [parity_bits-1:0] parity
);

  localparam logic [data_width-1:0] ONE = data_width'(1);

  // Coverage masks are folded into constants at elaboration, leaving one
  // XOR tree per parity bit.
  function automatic logic [data_width-1:0] cover_mask(int k);
    logic [data_width-1:0] m;
    m = '0;
    for (int pos = 1; pos <= total_width; pos++) begin
      if (!is_pow2(pos) && (((pos >> k) & 1) == 1))
        m = m | (ONE << data_index(pos));
    end
    return m;
  endfunction

  for (genvar k = 0; k < parity_bits; k++) begin : g_par
    localparam logic [data_width-1:0] MASK = cover_mask(k);
    assign parity[k] = ^(data & MASK);
  end

endmodule

// File: rtl/hamming_encoder.sv
// Two-stage valid/ready Hamming encoder with single-bit fault injection and a
// saturating count of emitted words.
module hamming_encoder
  import hamming_pkg::*;
#(
  parameter int parity_bits = 4,
  parameter int data_width  = (1 << parity_bits) - parity_bits - 1,
  parameter int total_width = (1 << parity_bits) - 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [data_width-1:0]  in_data,
  input  logic [parity_bits-1:0] inject_pos,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [total_width:1]   out_word,
  output logic [15:0]            words_sent
);

  localparam logic [total_width:1]   WORD_ONE = total_width'(1);
  localparam logic [parity_bits-1:0] INJ_OFF  = parity_bits'(INJ_NONE);

  logic                   s1_valid_q, s1_valid_d;
  logic [data_width-1:0]  s1_data_q, s1_data_d;
  logic [parity_bits-1:0] s1_inj_q, s1_inj_d;
  logic                   s2_valid_q, s2_valid_d;
  logic [total_width:1]   s2_word_q, s2_word_d;
  logic [15:0]            words_sent_q, words_sent_d;

  logic                   s1_adv, s2_adv;
  logic [parity_bits-1:0] parity;
  logic [total_width:1]   coded;
  logic [total_width:1]   inj_mask;

  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;

  hamming_parity_gen #(
    .parity_bits(parity_bits),
    .data_width (data_width),
    .total_width(total_width)
  ) u_par (
    .data  (s1_data_q),
    .parity(parity)
  );

  // Scatter data and parity into their 1-based positions.
  for (genvar pos = 1; pos <= total_width; pos++) begin : g_pos
    if (is_pow2(pos)) begin : g_p
      localparam int PI = $clog2(pos);
      assign coded[pos] = parity[PI];
    end else begin : g_d
      localparam int DI = data_index(pos);
      assign coded[pos] = s1_data_q[DI];
    end
  end

  assign inj_mask = (s1_inj_q == INJ_OFF) ? '0 : (WORD_ONE << (s1_inj_q - 1'b1));

  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_data_d    = s1_data_q;
    s1_inj_d     = s1_inj_q;
    s2_valid_d   = s2_valid_q;
    s2_word_d    = s2_word_q;
    words_sent_d = words_sent_q;

    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_data_d = in_data;
        s1_inj_d  = inject_pos;
      end
    end

    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) s2_word_d = coded ^ inj_mask;
    end

    if (s2_valid_q && out_ready && (words_sent_q != 16'hFFFF))
      words_sent_d = words_sent_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s1_data_q    <= '0;
      s1_inj_q     <= '0;
      s2_valid_q   <= 1'b0;
      s2_word_q    <= '0;
      words_sent_q <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_data_q    <= s1_data_d;
      s1_inj_q     <= s1_inj_d;
      s2_valid_q   <= s2_valid_d;
      s2_word_q    <= s2_word_d;
      words_sent_q <= words_sent_d;
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_word   = s2_word_q;
  assign words_sent = words_sent_q;

endmodule

// File: tb/tb_hamming_encoder.sv
// Randomized bench for hamming_encoder: arithmetic reference encoder and
// splitter, in-order scoreboard, stall stability and counter checks.
module tb_hamming_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [10:0] in_data;
  logic [3:0]  inject_pos;
  logic        out_valid;
  logic        out_ready;
  logic [15:1] out_word;
  logic [15:0] words_sent;

  hamming_encoder dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .inject_pos(inject_pos),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_word  (out_word),
    .words_sent(words_sent)
  );

  always #5 clk = ~clk;

  typedef struct {
    int word;
    int data;
    int inj;
  } item_t;

  item_t exp_q[$];
  int    n_chk  = 0;
  int    n_fail = 0;
  int    sent_m = 0;
  bit    stall_pend = 0;
  int    held_word = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit pow2(int i);
    return (i & (i - 1)) == 0;
  endfunction

  // Reference: place data in ascending non-power-of-two slots, then pick each
  // parity so every group XORs to zero, then flip the injected slot.
  function automatic int ref_enc(int d, int inj);
    int w = 0, di = 0;
    for (int pos = 1; pos <= 15; pos++)
      if (!pow2(pos)) begin
        w |= ((d >> di) & 1) << pos;
        di++;
      end
    for (int k = 0; k < 4; k++) begin
      int p = 0;
      for (int pos = 1; pos <= 15; pos++)
        if ((pos >> k) & 1) p ^= (w >> pos) & 1;
      w |= p << (1 << k);
    end
    if (inj != 0) w ^= 1 << inj;
    return w >> 1;
  endfunction

  function automatic int syndrome(int ow);
    int s = 0;
    for (int pos = 1; pos <= 15; pos++)
      if ((ow >> (pos - 1)) & 1) s ^= pos;
    return s;
  endfunction

  function automatic int recover(int ow);
    int s = syndrome(ow), d = 0, di = 0;
    if (s != 0) ow ^= 1 << (s - 1);
    for (int pos = 1; pos <= 15; pos++)
      if (!pow2(pos)) begin
        d |= ((ow >> (pos - 1)) & 1) << di;
        di++;
      end
    return d;
  endfunction

  // One clock cycle: drive at negedge, check settled outputs, book handshakes.
  task automatic cyc(input logic v, input int d, input int inj, input logic ordy,
                     output bit acc);
    int    inflight;
    item_t it;
    @(negedge clk);
    in_valid   = v;
    in_data    = 11'(d);
    inject_pos = 4'(inj);
    out_ready  = ordy;
    #1;
    inflight = exp_q.size();
    chk("words_sent", int'(words_sent), sent_m);
    chk("in_ready", int'(in_ready), int'((inflight < 2) || ordy));
    if (stall_pend) begin
      chk("stall_valid", int'(out_valid), 1);
      chk("stall_word", int'(out_word), held_word);
    end
    if (out_valid && exp_q.size() == 0) chk("spurious_out", int'(out_valid), 0);
    if (out_valid && out_ready && exp_q.size() != 0) begin
      it = exp_q.pop_front();
      chk("word", int'(out_word), it.word);
      chk("syndrome", syndrome(int'(out_word)), it.inj);
      chk("recover", recover(int'(out_word)), it.data);
      if (sent_m != 16'hFFFF) sent_m++;
    end
    stall_pend = out_valid && !out_ready;
    held_word  = int'(out_word);
    acc = in_valid && in_ready;
    if (acc) begin
      it.word = ref_enc(d, inj);
      it.data = d;
      it.inj  = inj;
      exp_q.push_back(it);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    sent_m = 0;
    stall_pend = 0;
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_word", int'(out_word), 0);
    chk("rst_words_sent", int'(words_sent), 0);
    chk("rst_in_ready", int'(in_ready), 1);
  endtask

  task automatic drain(input int budget);
    bit acc;
    for (int t = 0; t < budget && exp_q.size() != 0; t++) cyc(0, 0, 0, 1, acc);
    chk("drain_left", exp_q.size(), 0);
  endtask

  initial begin
    int  dir_d[4] = '{'h000, 'h001, 'h7FF, 'h000};
    int  dir_i[4] = '{0, 0, 0, 5};
    int  dir_w[4] = '{'h0000, 'h0007, 'h7FFF, 'h0010};
    bit  pat[4]   = '{1, 0, 0, 1};
    int  strm[8];
    int  idx;
    bit  acc;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; inject_pos = '0; out_ready = 1'b0;
    do_reset();

    // Directed words with two-cycle latency check
    for (int i = 0; i < 4; i++) begin
      cyc(1, dir_d[i], dir_i[i], 1, acc);
      chk("dir_accept", int'(acc), 1);
      cyc(0, 0, 0, 1, acc);
      chk("lat1_valid", int'(out_valid), 0);
      cyc(0, 0, 0, 1, acc);
      chk("lat2_valid", int'(out_valid), 1);
      chk("dir_word", int'(out_word), dir_w[i]);
    end
    cyc(0, 0, 0, 1, acc);
    chk("dir_count", int'(words_sent), 4);

    // Stream of 8 under 1,0,0,1 backpressure
    do_reset();
    for (int i = 0; i < 8; i++) strm[i] = int'($urandom_range(0, 2047));
    idx = 0;
    for (int t = 0; t < 80 && (idx < 8 || exp_q.size() != 0); t++) begin
      cyc(idx < 8, (idx < 8) ? strm[idx] : 0, 0, pat[t % 4], acc);
      if (acc) idx++;
    end
    chk("stream_accepted", idx, 8);
    chk("stream_left", exp_q.size(), 0);
    cyc(0, 0, 0, 0, acc);
    chk("stream_count", int'(words_sent), 8);

    // Reset with two words in flight
    cyc(1, 'h123, 0, 0, acc);
    cyc(1, 'h456, 0, 0, acc);
    cyc(0, 0, 0, 0, acc);
    chk("fill_full", int'(in_ready), 0);
    do_reset();
    for (int t = 0; t < 4; t++) begin
      cyc(0, 0, 0, 1, acc);
      chk("post_rst_valid", int'(out_valid), 0);
    end

    // Counter saturation
    @(negedge clk);
    force dut.words_sent_q = 16'hFFFE;
    #1 release dut.words_sent_q;
    sent_m = 'hFFFE;
    for (int i = 0; i < 3; i++) cyc(1, i, 0, 1, acc);
    drain(10);
    cyc(0, 0, 0, 1, acc);
    chk("sat_count", int'(words_sent), 'hFFFF);

    // Random traffic, random backpressure, occasional injection
    do_reset();
    for (int t = 0; t < 400; t++)
      cyc($urandom_range(0, 3) != 0, int'($urandom_range(0, 2047)),
          ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 15)) : 0,
          $urandom_range(0, 3) != 0, acc);
    drain(10);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
